game_tick_gen: RTL and testbench
================================

// Module: game_tick_gen
// PURPOSE
//  Multi-channel game timebase: N independent programmable-period tick generators driven from the single system clock.
//  Emits one-cycle clock-enable pulses (gravity drop, input repeat, frame refresh, ...) instead of derived clocks.
//  Adds runtime period reprogramming (level speed-up), per-channel pause, one-shot mode and restart.
//  Sits between the top-level clock/reset and the game FSM / renderer.
// PARAMETERS
//  N_CH           4         number of tick channels (1..16)
//  CNT_W          32        width of period and counter per channel
//  DEFAULT_PERIOD 50000000  period loaded into every channel at reset (0 = disabled)
// PORTS
//  clock       in   1                  system clock; all logic on posedge
//  reset       in   1                  synchronous, active-high reset
//  pause       in   1                  global pause; freezes all channels
//  ch_pause    in   N_CH               per-channel pause; bit i freezes channel i
//  cfg_we      in   1                  config write strobe, one cycle
//  cfg_sel     in   $clog2(N_CH) (min 1)  channel index for cfg write
//  cfg_period  in   CNT_W              new period, in clock cycles
//  cfg_oneshot in   1                  new mode: 1 = one-shot, 0 = periodic
//  restart     in   N_CH               bit i clears channel i counter and re-arms it
//  tick        out  N_CH               registered one-cycle tick pulse per channel
//  busy        out  N_CH               channel armed: period!=0 and not a finished one-shot
//  tick_clk    out  N_CH               50% square wave per channel (only with TICK_TOGGLE_OUT_EN)
// BEHAVIOUR
//  - Reset (sync, every posedge with reset=1): period=DEFAULT_PERIOD, mode=periodic, cnt=0, tick=0,
//    busy=(DEFAULT_PERIOD!=0), tick_clk=0. Reset overrides every other input.
//  - Channel i active when busy[i] & ~pause & ~ch_pause[i]. Active cycle: if cnt==period-1 then cnt<=0, tick<=1,
//    else cnt<=cnt+1, tick<=0. Period P => tick every P cycles, first tick P cycles after arm; P=1 => tick every cycle.
//  - Inactive cycle (paused or not busy): cnt holds, tick<=0. Unpause resumes from the held count; no lost or extra tick.
//  - One-shot: on the cycle tick is set, busy<=0; channel then idles with cnt=0 until restart or cfg write.
//  - Period 0: busy=0, no ticks, cnt held at 0.
//  - cfg write (cfg_we & cfg_sel<N_CH): period<=cfg_period, mode<=cfg_oneshot, cnt<=0, tick<=0,
//    busy<=(cfg_period!=0). Takes effect next cycle. cfg_sel>=N_CH: write ignored, no state change.
//  - restart[i]: cnt<=0, tick<=0, busy<=(period!=0). Allowed while paused: counter cleared, stays frozen.
//  - Priority per channel: reset > cfg write > restart > count. cfg and restart on the same channel in the same cycle: cfg wins.
//  - Counter arithmetic: unsigned CNT_W; compare against period-1 computed in CNT_W bits; cnt never exceeds period-1,
//    so no wrap past 2^CNT_W-1.
// CONFIGURATION
//  - TICK_TOGGLE_OUT_EN defined: tick_clk port present; tick_clk[i] toggles on every tick[i]
//    (period 2P square wave, direct replacement for legacy divided clocks); cleared by reset only, holds on pause/cfg/restart.
//  - Not defined: tick_clk port and its flops absent; all other behaviour identical.
// STRUCTURE
//  - Package game_timing_pkg: CLK_HZ (100_000_000) constant and period constants FRAME_60HZ, GRAVITY_L0, REPEAT_DELAY;
//    function hz_to_period(hz) = CLK_HZ/hz.
//  - Sub-module game_tick_channel: one channel (period/mode regs, counter, tick, busy, optional toggle);
//    the top level decodes cfg_sel/restart and instantiates N_CH copies in a generate loop.
// TESTING
//  - Reset, DEFAULT_PERIOD=4, N_CH=2, idle inputs -> tick[0] high exactly 1 cycle at cycles 4,8,12 after reset release; busy=2'b11.
//  - cfg write ch1 period=3 oneshot=1 -> single tick[1] 3 cycles later, busy[1]=0 from that cycle; no more ticks in 20 cycles.
//  - pause high for 10 cycles at cnt=2 (P=4) -> no ticks during pause; next tick 2 cycles after pause drops.
//  - cfg write period=0 -> busy=0, tick stays 0; then cfg period=1 -> tick high every cycle.
//  - Same cycle cfg_we(ch0,P=5) and restart[0] -> P=5 applied, first tick 5 cycles later; cfg_sel=3 with N_CH=2 -> no change.
//  - TICK_TOGGLE_OUT_EN, P=2 -> tick_clk[0] period 4 cycles, 50% duty; reset mid-count -> all outputs 0 next cycle.

Source files
------------

// File: rtl/game_timing_pkg.sv
// game_timing_pkg: clock rate, common game periods and helpers shared by the tick generator.
// Revision 1.0
`default_nettype none

package game_timing_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  function automatic int unsigned hz_to_period(input int unsigned hz);
    return CLK_HZ / hz;
  endfunction

  function automatic int sel_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  localparam int unsigned FRAME_60HZ   = CLK_HZ / 60;
  localparam int unsigned GRAVITY_L0   = CLK_HZ;
  localparam int unsigned REPEAT_DELAY = CLK_HZ / 10;

endpackage

`default_nettype wire

// File: rtl/game_tick_channel.sv
// game_tick_channel: one programmable-period tick channel with pause, one-shot and restart.
// Optional TICK_TOGGLE_OUT_EN adds a square-wave output toggled on every tick. Revision 1.0
`default_nettype none

module game_tick_channel
  import game_timing_pkg::*;
#(
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             restart,
`ifdef TICK_TOGGLE_OUT_EN
  output logic             tick_clk,
`endif
  output logic             tick,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  mode_e            mode;

  // period-1 wraps to all ones for period 0, but busy is low then so it is never compared
  assign last = period - ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      period <= RST_PERIOD;
      mode   <= MODE_PERIODIC;
      cnt    <= '0;
      tick   <= 1'b0;
      busy   <= (RST_PERIOD != '0);
    end else if (cfg_wr) begin
      period <= cfg_period;
      mode   <= cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
      cnt    <= '0;
      tick   <= 1'b0;
      busy   <= (cfg_period != '0);
    end else if (restart) begin
      cnt    <= '0;
      tick   <= 1'b0;
      busy   <= (period != '0);
    end else if (busy && run) begin
      if (cnt == last) begin
        cnt  <= '0;
        tick <= 1'b1;
        if (mode == MODE_ONESHOT) busy <= 1'b0;
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

`ifdef TICK_TOGGLE_OUT_EN
  logic fire;
  assign fire = !cfg_wr && !restart && busy && run && (cnt == last);

  always_ff @(posedge clock) begin
    if (reset)     tick_clk <= 1'b0;
    else if (fire) tick_clk <= ~tick_clk;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/game_tick_gen.sv
// game_tick_gen: N_CH independent tick channels sharing one clock, config port and global pause.
// Optional TICK_TOGGLE_OUT_EN exposes a per-channel square wave on tick_clk. Revision 1.0
`default_nettype none

module game_tick_gen
  import game_timing_pkg::*;
#(
  parameter int          N_CH           = 4,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pause,
  input  logic [N_CH-1:0]           ch_pause,
  input  logic                      cfg_we,
  input  logic [sel_w(N_CH)-1:0]    cfg_sel,
  input  logic [CNT_W-1:0]          cfg_period,
  input  logic                      cfg_oneshot,
  input  logic [N_CH-1:0]           restart,
`ifdef TICK_TOGGLE_OUT_EN
  output logic [N_CH-1:0]           tick_clk,
`endif
  output logic [N_CH-1:0]           tick,
  output logic [N_CH-1:0]           busy
);

  localparam int SEL_W = sel_w(N_CH);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic cfg_hit;
      // out-of-range selects never equal any instantiated index, so they are dropped here
      assign cfg_hit = cfg_we && (cfg_sel == SEL_W'(i));

      game_tick_channel #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
        .clock       (clock),
        .reset       (reset),
        .run         (!pause && !ch_pause[i]),
        .cfg_wr      (cfg_hit),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .restart     (restart[i]),
`ifdef TICK_TOGGLE_OUT_EN
        .tick_clk    (tick_clk[i]),
`endif
        .tick        (tick[i]),
        .busy        (busy[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: directed and randomized checks of game_tick_gen against a countdown reference model.
`default_nettype none

module tb_game_tick_gen;
  localparam int N     = 3;
  localparam int CNT_W = 8;
  localparam int DEFP  = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pause = 1'b0;
  logic [N-1:0]     ch_pause = '0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_sel = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic             cfg_oneshot = 1'b0;
  logic [N-1:0]     restart = '0;
  logic [N-1:0]     tick;
  logic [N-1:0]     busy;
`ifdef TICK_TOGGLE_OUT_EN
  logic [N-1:0]     tick_clk;
`endif

  game_tick_gen #(.N_CH(N), .CNT_W(CNT_W), .DEFAULT_PERIOD(DEFP)) dut (
    .clock       (clk),
    .reset       (reset),
    .pause       (pause),
    .ch_pause    (ch_pause),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .restart     (restart),
`ifdef TICK_TOGGLE_OUT_EN
    .tick_clk    (tick_clk),
`endif
    .tick        (tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // reference: cycles remaining until the next tick, reloaded with the period on each tick/arm
  int           m_per [N];
  int           m_rem [N];
  bit           m_os  [N];
  bit           m_arm [N];
  logic [N-1:0] e_tick = '0;
  logic [N-1:0] e_clk  = '0;

  function automatic logic [N-1:0] e_busy();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_arm[c];
    return v;
  endfunction

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        m_per[c] = DEFP; m_os[c] = 0; m_arm[c] = (DEFP != 0); m_rem[c] = DEFP;
        e_tick[c] = 0; e_clk[c] = 0;
      end else begin
        e_tick[c] = 0;
        if (cfg_we && int'(cfg_sel) == c) begin
          m_per[c] = int'(cfg_period); m_os[c] = cfg_oneshot;
          m_arm[c] = (m_per[c] != 0); m_rem[c] = m_per[c];
        end else if (restart[c]) begin
          m_arm[c] = (m_per[c] != 0); m_rem[c] = m_per[c];
        end else if (m_arm[c] && !pause && !ch_pause[c]) begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            e_tick[c] = 1; e_clk[c] = ~e_clk[c]; m_rem[c] = m_per[c];
            if (m_os[c]) m_arm[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, got, exp, $time);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tick", tick, e_tick);
    check("busy", busy, e_busy());
`ifdef TICK_TOGGLE_OUT_EN
    check("tick_clk", tick_clk, e_clk);
`endif
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic cfg(input int sel, input int per, input bit os);
    cfg_we = 1; cfg_sel = 2'(sel); cfg_period = CNT_W'(per); cfg_oneshot = os;
    cycle();
    cfg_we = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    run(2);
    reset = 0;
  endtask

  int tick0_count;

  initial begin
    // reset state and default period
    run(2);
    check("rst_tick", tick, '0);
    check("rst_busy", busy, 3'b111);
    reset = 0;
    tick0_count = 0;
    for (int k = 1; k <= 13; k++) begin
      cycle();
      if (tick[0]) tick0_count++;
    end
    check("default_ticks", 3'(tick0_count), 3'd3);

    // one-shot on channel 1
    cfg(1, 3, 1);
    run(25);
    check("oneshot_busy", busy & 3'b010, 3'b000);

    // global pause at cnt=2 with P=4
    do_reset();
    run(2);
    pause = 1;
    run(10);
    pause = 0;
    run(8);

    // period 0 then period 1
    cfg(0, 0, 0);
    run(5);
    check("p0_busy", busy & 3'b001, 3'b000);
    cfg(0, 1, 0);
    run(5);

    // cfg and restart together: cfg wins; invalid select ignored
    restart = 3'b001;
    cfg(0, 5, 0);
    restart = '0;
    run(12);
    cfg(3, 2, 1);
    run(10);

    // P=2 square wave, then reset mid-count
    cfg(0, 2, 0);
    run(9);
    do_reset();
    check("midrst_tick", tick, '0);
`ifdef TICK_TOGGLE_OUT_EN
    check("midrst_clk", tick_clk, '0);
`endif
    run(6);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      reset       = ($urandom_range(0, 99) == 0);
      pause       = ($urandom_range(0, 7) == 0);
      ch_pause    = N'($urandom_range(0, 7)) & N'($urandom_range(0, 7));
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_sel     = 2'($urandom_range(0, 3));
      cfg_period  = CNT_W'($urandom_range(0, 6));
      cfg_oneshot = ($urandom_range(0, 2) == 0);
      restart     = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 7)) : '0;
      cycle();
    end
    reset = 0; pause = 0; ch_pause = '0; cfg_we = 0; restart = '0;
    run(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
